// File: rtl/syn_accum_pkg.sv
// syn_accum_pkg
//   Shared definitions for the synaptic integration stage and the LIF neuron
//   stage that consumes its output.
//   - state_t : FSM encoding for syn_accum (legacy encodings kept explicit).
//   - sat_max / sat_min : bounds of a signed v_size-bit saturating value.
package syn_accum_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ACCUM = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    function automatic int sat_max(input int v_size);
        return (1 << (v_size - 1)) - 1;
    endfunction

    function automatic int sat_min(input int v_size);
        return -(1 << (v_size - 1));
    endfunction

endpackage

// File: rtl/syn_sat_add.sv
// syn_sat_add
//   Combinational V_SIZE-bit signed saturating adder.
//   Ports:
//     a, b : signed operands
//     sum  : a + b clipped to [sat_min, sat_max]
//   Overflow is detected from operand signs: two non-negative operands giving
//   a negative raw result clip to max, two negative operands giving a
//   non-negative raw result clip to min.
module syn_sat_add
    import syn_accum_pkg::*;
#(
    parameter int V_SIZE = 4
) (
    input  logic signed [V_SIZE-1:0] a,
    input  logic signed [V_SIZE-1:0] b,
    output logic signed [V_SIZE-1:0] sum
);

    localparam logic signed [V_SIZE-1:0] SAT_MAX = V_SIZE'(sat_max(V_SIZE));
    localparam logic signed [V_SIZE-1:0] SAT_MIN = V_SIZE'(sat_min(V_SIZE));

    logic signed [V_SIZE-1:0] raw;

    always_comb begin
        raw = a + b;
        sum = raw;
        if (!a[V_SIZE-1] && !b[V_SIZE-1] && raw[V_SIZE-1]) begin
            sum = SAT_MAX;
        end else if (a[V_SIZE-1] && b[V_SIZE-1] && !raw[V_SIZE-1]) begin
            sum = SAT_MIN;
        end
    end

endmodule

// File: rtl/syn_accum.sv
// syn_accum
//   Serial synaptic integration: one synapse per cycle, saturating after every
//   add in ascending index order, result handed to the LIF neuron stage.
//   Ports:
//     clk, rst   : clock, synchronous active-high reset
//     spikes_in  : presynaptic vector, latched when start & ready
//     start      : request to integrate spikes_in
//     ready      : high in IDLE; start accepted only then
//     w_we, w_addr, w_data : weight register file write port (any state)
//     sum_out    : signed saturated sum, held until the next result
//     sum_valid  : one-cycle pulse when sum_out is updated
//   Build option SYN_SKIP_EN: visit only the set bits of the latched vector
//   through a priority encoder (latency popcount+1); otherwise every index is
//   visited (latency N_IN+1). The numeric result is identical.
module syn_accum
    import syn_accum_pkg::*;
#(
    parameter int N_IN   = 8,
    parameter int V_SIZE = 4,
    parameter int W_SIZE = 4,
    localparam int AW    = $clog2(N_IN)
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [N_IN-1:0]          spikes_in,
    input  logic                     start,
    output logic                     ready,
    input  logic                     w_we,
    input  logic [AW-1:0]            w_addr,
    input  logic [W_SIZE-1:0]        w_data,
    output logic signed [V_SIZE-1:0] sum_out,
    output logic                     sum_valid
);

    state_t                   state_q, state_d;
    logic signed [V_SIZE-1:0] acc_q, acc_d;
    logic signed [V_SIZE-1:0] sum_q, sum_d;
    logic                     sum_valid_q, sum_valid_d;
    logic signed [W_SIZE-1:0] w_q [N_IN];
    logic signed [W_SIZE-1:0] w_d [N_IN];

    logic [AW-1:0]            rd_idx;
    logic                     rd_active;
    logic signed [V_SIZE-1:0] w_ext;
    logic signed [V_SIZE-1:0] add_out;

`ifdef SYN_SKIP_EN
    logic [N_IN-1:0] mask_q, mask_d;

    // Lowest remaining set bit; descending scan so the lowest index wins.
    always_comb begin
        rd_idx = '0;
        for (int unsigned i = N_IN; i > 0; i--) begin
            if (mask_q[i-1]) rd_idx = AW'(i - 1);
        end
    end

    assign rd_active = 1'b1;
`else
    logic [N_IN-1:0] spk_q, spk_d;
    logic [AW-1:0]   idx_q, idx_d;

    assign rd_idx    = idx_q;
    assign rd_active = spk_q[idx_q];
`endif

    // Reads use the registered file, so a same-cycle write sees the old value.
    assign w_ext = V_SIZE'(w_q[rd_idx]);

    syn_sat_add #(.V_SIZE(V_SIZE)) u_sat_add (
        .a   (acc_q),
        .b   (w_ext),
        .sum (add_out)
    );

    always_comb begin
        w_d = w_q;
        if (w_we) w_d[w_addr] = w_data;
    end

    always_comb begin
        state_d     = state_q;
        acc_d       = acc_q;
        sum_d       = sum_q;
        sum_valid_d = 1'b0;
`ifdef SYN_SKIP_EN
        mask_d      = mask_q;
`else
        spk_d       = spk_q;
        idx_d       = idx_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    acc_d = '0;
`ifdef SYN_SKIP_EN
                    mask_d  = spikes_in;
                    state_d = (spikes_in == '0) ? ST_DONE : ST_ACCUM;
`else
                    spk_d   = spikes_in;
                    idx_d   = '0;
                    state_d = ST_ACCUM;
`endif
                end
            end
            ST_ACCUM: begin
                if (rd_active) acc_d = add_out;
`ifdef SYN_SKIP_EN
                mask_d = mask_q & ~(N_IN'(1) << rd_idx);
                if (mask_d == '0) state_d = ST_DONE;
`else
                if (idx_q == AW'(N_IN - 1)) state_d = ST_DONE;
                else                        idx_d   = idx_q + 1'b1;
`endif
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
        // Result registers load on entry to DONE so sum_out and sum_valid
        // are both visible during the DONE cycle.
        if (state_d == ST_DONE) begin
            sum_d       = acc_d;
            sum_valid_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            acc_q       <= '0;
            sum_q       <= '0;
            sum_valid_q <= 1'b0;
            for (int unsigned i = 0; i < N_IN; i++) w_q[i] <= '0;
`ifdef SYN_SKIP_EN
            mask_q      <= '0;
`else
            spk_q       <= '0;
            idx_q       <= '0;
`endif
        end else begin
            state_q     <= state_d;
            acc_q       <= acc_d;
            sum_q       <= sum_d;
            sum_valid_q <= sum_valid_d;
            w_q         <= w_d;
`ifdef SYN_SKIP_EN
            mask_q      <= mask_d;
`else
            spk_q       <= spk_d;
            idx_q       <= idx_d;
`endif
        end
    end

    assign ready     = (state_q == ST_IDLE);
    assign sum_out   = sum_q;
    assign sum_valid = sum_valid_q;

endmodule
